// File: rtl/rsc_pkg.sv
// Shared definitions for the 8-state RSC constituent encoder (g0 = 13, g1 = 15 octal).
// Provides the FSM encoding, generator taps and the single trellis-step function.
package rsc_pkg;

  typedef enum logic {
    ENC  = 1'b0,
    TERM = 1'b1
  } fsm_t;

  localparam int NUM_STATES = 8;
  localparam int MEM        = $clog2(NUM_STATES);
  localparam logic [3:0] G0 = 4'o13;
  localparam logic [3:0] G1 = 4'o15;

  // s = {s1,s2,s3}; tap bit k of a generator weights D^(MEM-k) so s1 lines up with bit MEM-1.
  function automatic logic [1:0] rsc_step(input logic u, input logic [MEM-1:0] s);
    logic a;
    logic p;
    a = u ^ (^(s & G0[MEM-1:0]));
    p = (a & G1[MEM]) ^ (^(s & G1[MEM-1:0]));
    return {a, p};
  endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// Combinational RSC trellis branch: parity bit and next state for input u from state s.
// Kept separate from the sequencing logic in the same way the decoder splits its ACS datapath.
module rsc_trellis_step
  import rsc_pkg::*;
(
  input  logic           u,
  input  logic [MEM-1:0] s,
  output logic           p,
  output logic [MEM-1:0] s_next
);

  logic [1:0] ap_s;

  // evaluate feedback bit and parity for this branch
  always_comb begin
    ap_s = rsc_step(u, s);
  end

  assign p      = ap_s[0];
  assign s_next = {ap_s[1], s[MEM-1:1]};

endmodule

// File: rtl/rsc_tail_encoder.sv
// RSC block encoder: BLK_LEN information steps then MEM termination steps back to state 0.
// Define SYM_MAP_EN to emit BPSK symbols (+/-AMP) instead of raw 0/1 symbols.
module rsc_tail_encoder
  import rsc_pkg::*;
#(
  parameter int BLK_LEN = 40,
  parameter int CNT_W   = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1,
  parameter int SYM_W   = 12,
  parameter int AMP     = 256
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_bit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SYM_W-1:0] out_sys,
  output logic signed [SYM_W-1:0] out_par,
  output logic                    out_tail,
  output logic                    out_last
);

`ifdef SYM_MAP_EN
  localparam logic signed [SYM_W-1:0] AMP_POS = SYM_W'(AMP);
`endif

  fsm_t             fsm_r;
  logic [MEM-1:0]   s_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       tcnt_r;
  logic             slot_free_s;
  logic             step_u_s;
  logic             step_p_s;
  logic [MEM-1:0]   s_next_s;

  function automatic logic signed [SYM_W-1:0] map_sym(input logic b);
`ifdef SYM_MAP_EN
    return b ? -AMP_POS : AMP_POS;
`else
    return {{(SYM_W-1){1'b0}}, b};
`endif
  endfunction

  assign slot_free_s = !out_valid || out_ready;
  assign in_ready    = (fsm_r == ENC) && slot_free_s;

  // branch input: the information bit, or s2^s3 during termination so the feedback bit is 0
  always_comb begin
    if (fsm_r == TERM) begin
      step_u_s = s_r[1] ^ s_r[0];
    end else begin
      step_u_s = in_bit;
    end
  end

  rsc_trellis_step u_step (
    .u      (step_u_s),
    .s      (s_r),
    .p      (step_p_s),
    .s_next (s_next_s)
  );

  // block sequencing, trellis state and registered output pair; everything holds while stalled
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      fsm_r     <= ENC;
      s_r       <= '0;
      count_r   <= '0;
      tcnt_r    <= 2'd0;
      out_valid <= 1'b0;
      out_sys   <= '0;
      out_par   <= '0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
    end else if (slot_free_s) begin
      case (fsm_r)
        ENC: begin
          out_tail <= 1'b0;
          out_last <= 1'b0;
          if (in_valid) begin
            out_valid <= 1'b1;
            out_sys   <= map_sym(step_u_s);
            out_par   <= map_sym(step_p_s);
            s_r       <= s_next_s;
            if (count_r == CNT_W'(BLK_LEN - 1)) begin
              fsm_r   <= TERM;
              count_r <= '0;
            end else begin
              count_r <= count_r + CNT_W'(1);
            end
          end else begin
            out_valid <= 1'b0;
          end
        end
        TERM: begin
          out_valid <= 1'b1;
          out_sys   <= map_sym(step_u_s);
          out_par   <= map_sym(step_p_s);
          out_tail  <= 1'b1;
          out_last  <= (tcnt_r == 2'(MEM - 1));
          s_r       <= s_next_s;
          if (tcnt_r == 2'(MEM - 1)) begin
            fsm_r  <= ENC;
            tcnt_r <= 2'd0;
          end else begin
            tcnt_r <= tcnt_r + 2'd1;
          end
        end
        default: begin
          fsm_r <= ENC;
        end
      endcase
    end
  end

endmodule
